// File: rtl/manchester_frame_decoder_pkg.sv
// Shared constants for the Manchester frame decoder: state encodings and default framing values.
package manchester_frame_decoder_pkg;

  localparam logic [0:0] ST_HUNT = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  localparam int unsigned DATA_W_DEF    = 8;
  localparam int unsigned SYNC_W_DEF    = 8;
  localparam logic [7:0]  SYNC_WORD_DEF = 8'b1010_1011;
  localparam int unsigned MAX_GAP_DEF   = 32;

  // Mid-bit edge counter only needs to distinguish 0, 1 and "2 or more".
  function automatic logic [1:0] edge_cnt_inc(input logic [1:0] cnt);
    return (cnt == 2'd2) ? 2'd2 : cnt + 2'd1;
  endfunction

endpackage

// File: rtl/manchester_frame_decoder_if.sv
// Byte stream and status bundle between the frame decoder (master) and its consumer (slave).
interface manchester_frame_decoder_if #(
  parameter int unsigned DATA_W = 8
) ();

  logic [DATA_W-1:0] dataOut;
  logic              dataValid;
  logic              dataReady;
  logic              syncLock;
  logic              codeErr;
  logic              overrun;

  modport master (
    output dataOut,
    output dataValid,
    input  dataReady,
    output syncLock,
    output codeErr,
    output overrun
  );

  modport slave (
    input  dataOut,
    input  dataValid,
    output dataReady,
    input  syncLock,
    input  codeErr,
    input  overrun
  );

endinterface

// File: rtl/manchester_edge_detect.sv
// Rising-edge strobe for the recovered bit clock and any-edge pulse for the raw Manchester line.
module manchester_edge_detect (
  input  logic clk,
  input  logic globalRest,
  input  logic balanceCLK,
  input  logic manIn,
  output logic strobe,
  output logic manEdge
);

  logic r_bal_prev;
  logic r_man_prev;

  always_ff @(posedge clk or negedge globalRest) begin
    if (!globalRest) begin
      r_bal_prev <= 1'b0;
      r_man_prev <= 1'b0;
    end else begin
      r_bal_prev <= balanceCLK;
      r_man_prev <= manIn;
    end
  end

  assign strobe  = balanceCLK & ~r_bal_prev;
  assign manEdge = manIn ^ r_man_prev;

endmodule

// File: rtl/manchester_frame_decoder.sv
// Hunts for the sync word on the strobed Manchester line, then deserializes bytes into a
// one-entry valid/ready buffer while flagging code violations, strobe loss and overrun.
module manchester_frame_decoder
  import manchester_frame_decoder_pkg::*;
#(
  parameter int unsigned       DATA_W    = DATA_W_DEF,
  parameter int unsigned       SYNC_W    = SYNC_W_DEF,
  parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_WORD_DEF,
  parameter int unsigned       MAX_GAP   = MAX_GAP_DEF
) (
  input  logic                       clk,
  input  logic                       globalRest,
  input  logic                       manIn,
  input  logic                       balanceCLK,
  manchester_frame_decoder_if.master bus
);

  localparam int unsigned       GAP_W    = $clog2(MAX_GAP + 1);
  localparam int unsigned       BIT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [GAP_W-1:0]  GAP_MAX  = GAP_W'(MAX_GAP);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(MAX_GAP - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_W - 1);

  logic w_strobe;
  logic w_man_edge;

  manchester_edge_detect u_edge (
    .clk        (clk),
    .globalRest (globalRest),
    .balanceCLK (balanceCLK),
    .manIn      (manIn),
    .strobe     (w_strobe),
    .manEdge    (w_man_edge)
  );

  logic [0:0]        r_state, w_state_d;
  logic [SYNC_W-1:0] r_sync_sh, w_sync_d;
  logic [DATA_W-1:0] r_data_sh, w_data_d;
  logic [BIT_W-1:0]  r_bit_cnt, w_bit_d;
  logic              r_chk_en, w_chk_d;
  logic [1:0]        r_edge_cnt;
  logic [GAP_W-1:0]  r_gap;
  logic [DATA_W-1:0] r_data_out;
  logic              r_data_valid;
  logic              r_code_err;
  logic              r_overrun;

  logic              w_viol;
  logic              w_loss;
  logic              w_load;
  logic [SYNC_W-1:0] w_sync_nxt;
  logic [DATA_W-1:0] w_word;

  // An edge seen in the strobe cycle itself still belongs to the closing bit cell.
  assign w_viol     = w_strobe & r_chk_en & (r_edge_cnt == 2'd0) & ~w_man_edge;
  assign w_loss     = ~w_strobe & (r_gap >= GAP_LAST);
  assign w_sync_nxt = {r_sync_sh[SYNC_W-2:0], manIn};
  assign w_word     = {r_data_sh[DATA_W-2:0], manIn};

  always_comb begin
    w_state_d = r_state;
    w_sync_d  = r_sync_sh;
    w_data_d  = r_data_sh;
    w_bit_d   = r_bit_cnt;
    w_chk_d   = r_chk_en | w_strobe;
    w_load    = 1'b0;
    case (r_state)
      ST_HUNT: begin
        if (w_strobe) begin
          if (w_sync_nxt == SYNC_WORD) begin
            w_state_d = ST_LOCK;
            w_sync_d  = '0;
            w_data_d  = '0;
            w_bit_d   = '0;
          end else begin
            w_sync_d = w_sync_nxt;
          end
        end
      end
      ST_LOCK: begin
        if (w_viol || w_loss) begin
          // The next strobe after losing lock has no valid reference cell to check against.
          w_state_d = ST_HUNT;
          w_data_d  = '0;
          w_bit_d   = '0;
          w_chk_d   = 1'b0;
        end else if (w_strobe) begin
          w_data_d = w_word;
          if (r_bit_cnt == BIT_LAST) begin
            w_load  = 1'b1;
            w_bit_d = '0;
          end else begin
            w_bit_d = r_bit_cnt + 1'b1;
          end
        end
      end
      default: w_state_d = ST_HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge globalRest) begin
    if (!globalRest) begin
      r_state   <= ST_HUNT;
      r_sync_sh <= '0;
      r_data_sh <= '0;
      r_bit_cnt <= '0;
      r_chk_en  <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_sync_sh <= w_sync_d;
      r_data_sh <= w_data_d;
      r_bit_cnt <= w_bit_d;
      r_chk_en  <= w_chk_d;
    end
  end

  always_ff @(posedge clk or negedge globalRest) begin
    if (!globalRest) begin
      r_edge_cnt <= 2'd0;
      r_gap      <= '0;
    end else begin
      if (w_strobe) begin
        r_edge_cnt <= 2'd0;
      end else if (w_man_edge) begin
        r_edge_cnt <= edge_cnt_inc(r_edge_cnt);
      end
      if (w_strobe) begin
        r_gap <= '0;
      end else if (r_gap != GAP_MAX) begin
        r_gap <= r_gap + 1'b1;
      end
    end
  end

  // One-entry buffer: a full slot accepts a new word only if it is drained on the same edge.
  always_ff @(posedge clk or negedge globalRest) begin
    if (!globalRest) begin
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_code_err   <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_code_err <= w_viol;
      r_overrun  <= w_load & r_data_valid & ~bus.dataReady;
      if (w_load && (!r_data_valid || bus.dataReady)) begin
        r_data_out   <= w_word;
        r_data_valid <= 1'b1;
      end else if (r_data_valid && bus.dataReady) begin
        r_data_valid <= 1'b0;
      end
    end
  end

  assign bus.dataOut   = r_data_out;
  assign bus.dataValid = r_data_valid;
  assign bus.syncLock  = (r_state == ST_LOCK);
  assign bus.codeErr   = r_code_err;
  assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_manchester_frame_decoder.sv
// Directed bench for manchester_frame_decoder: a byte-level vector table plus hand-written
// sequences for reset, code violation, strobe loss, overrun drain and accept-and-load.
module tb_manchester_frame_decoder;

  logic       clk;
  logic       globalRest;
  logic       manIn;
  logic       balanceCLK;
  logic       dataReady;

  int unsigned n_chk;
  int unsigned n_pass;
  int unsigned cnt_cerr;
  int unsigned cnt_ovr;
  int unsigned cnt_valid;

  logic       obs_pre_lock;
  logic       obs_lock;
  logic       obs_valid;
  logic [7:0] obs_data;
  logic       obs_cerr;
  logic       obs_ovr;

  manchester_frame_decoder_if #(.DATA_W(8)) bus ();

  assign bus.dataReady = dataReady;

  manchester_frame_decoder dut (
    .clk        (clk),
    .globalRest (globalRest),
    .manIn      (manIn),
    .balanceCLK (balanceCLK),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.codeErr)   cnt_cerr++;
    if (bus.overrun)   cnt_ovr++;
    if (bus.dataValid) cnt_valid++;
  end

  typedef struct {
    logic [7:0] byte_v;
    logic       ready;
    logic       exp_pre_lock;
    logic       exp_lock;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_ovr;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One 16-clk bit cell; balanceCLK rises at cycle 10, so the strobe edge samples the 2nd half.
  task automatic send_cell(input logic first, input logic second, input logic pulse);
    logic rsave;
    rsave = dataReady;
    for (int c = 0; c < 16; c++) begin
      manIn      = (c < 8) ? first : second;
      balanceCLK = (c >= 10);
      if (pulse) dataReady = (c == 10) ? 1'b1 : rsave;
      tick();
      if (c == 9) obs_pre_lock = bus.syncLock;
      if (c == 10) begin
        obs_lock  = bus.syncLock;
        obs_valid = bus.dataValid;
        obs_data  = bus.dataOut;
        obs_cerr  = bus.codeErr;
        obs_ovr   = bus.overrun;
      end
    end
  endtask

  task automatic send_bit(input logic b, input logic pulse);
    send_cell(~b, b, pulse);
  endtask

  task automatic send_byte(input logic [7:0] v, input logic pulse_last);
    for (int i = 7; i >= 0; i--) send_bit(v[i], pulse_last && (i == 0));
  endtask

  initial begin
    int unsigned c0;
    int unsigned v0;
    n_chk      = 0;
    n_pass     = 0;
    cnt_cerr   = 0;
    cnt_ovr    = 0;
    cnt_valid  = 0;
    globalRest = 1'b0;
    manIn      = 1'b0;
    balanceCLK = 1'b0;
    dataReady  = 1'b0;

    vecs[0] = '{8'hAB, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{8'h5C, 1'b1, 1'b1, 1'b1, 1'b1, 8'h5C, 1'b0};
    vecs[2] = '{8'h3F, 1'b1, 1'b1, 1'b1, 1'b1, 8'h3F, 1'b0};
    vecs[3] = '{8'h11, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0};
    vecs[4] = '{8'h22, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1};
    vecs[5] = '{8'h33, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1};

    repeat (3) tick();
    check("reset_lock", 32'(bus.syncLock), 32'd0);
    check("reset_valid", 32'(bus.dataValid), 32'd0);
    check("reset_data", 32'(bus.dataOut), 32'd0);
    check("reset_flags", 32'({bus.codeErr, bus.overrun}), 32'd0);
    globalRest = 1'b1;
    tick();

    // Reset mid-frame with a held byte and a partial byte in flight.
    send_byte(8'hAB, 1'b0);
    send_byte(8'h77, 1'b0);
    check("pre_rst_valid", 32'(obs_valid), 32'd1);
    check("pre_rst_data", 32'(obs_data), 32'h77);
    for (int i = 0; i < 4; i++) send_bit(1'(i % 2), 1'b0);
    check("pre_rst_lock", 32'(bus.syncLock), 32'd1);
    globalRest = 1'b0;
    #1;
    check("rst_async_lock", 32'(bus.syncLock), 32'd0);
    check("rst_async_valid", 32'(bus.dataValid), 32'd0);
    check("rst_async_data", 32'(bus.dataOut), 32'd0);
    manIn      = 1'b0;
    balanceCLK = 1'b0;
    repeat (3) tick();
    globalRest = 1'b1;
    tick();

    // Nominal frame, then overrun sequence.
    c0 = cnt_valid;
    for (int k = 0; k < 6; k++) begin
      dataReady = vecs[k].ready;
      send_byte(vecs[k].byte_v, 1'b0);
      if (k == 2) check("valid_pulse_cycles", cnt_valid - c0, 32'd2);
      check($sformatf("v%0d_pre_lock", k), 32'(obs_pre_lock), 32'(vecs[k].exp_pre_lock));
      check($sformatf("v%0d_lock", k), 32'(obs_lock), 32'(vecs[k].exp_lock));
      check($sformatf("v%0d_valid", k), 32'(obs_valid), 32'(vecs[k].exp_valid));
      check($sformatf("v%0d_data", k), 32'(obs_data), 32'(vecs[k].exp_data));
      check($sformatf("v%0d_ovr", k), 32'(obs_ovr), 32'(vecs[k].exp_ovr));
    end
    check("ovr_pulse_count", cnt_ovr, 32'd2);
    check("no_cerr_nominal", cnt_cerr, 32'd0);

    dataReady = 1'b1;
    tick();
    dataReady = 1'b0;
    check("drain_valid", 32'(bus.dataValid), 32'd0);
    check("drain_data", 32'(bus.dataOut), 32'h11);

    // Code violation: cell held at the previous line level, so no transition at all.
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    c0 = cnt_cerr;
    send_cell(manIn, manIn, 1'b0);
    check("viol_cerr", 32'(obs_cerr), 32'd1);
    check("viol_lock", 32'(obs_lock), 32'd0);
    check("viol_cerr_count", cnt_cerr - c0, 32'd1);
    send_byte(8'hAB, 1'b0);
    check("relock_lock", 32'(obs_lock), 32'd1);
    check("relock_valid", 32'(obs_valid), 32'd0);
    dataReady = 1'b1;
    send_byte(8'h96, 1'b0);
    check("relock_data", 32'(obs_data), 32'h96);
    check("relock_valid2", 32'(obs_valid), 32'd1);

    // Strobe loss with a byte held in the buffer.
    dataReady = 1'b0;
    send_byte(8'h5A, 1'b0);
    check("loss_pre_data", 32'(obs_data), 32'h5A);
    balanceCLK = 1'b0;
    repeat (26) tick();
    check("loss_lock_31", 32'(bus.syncLock), 32'd1);
    tick();
    check("loss_lock_32", 32'(bus.syncLock), 32'd0);
    check("loss_valid", 32'(bus.dataValid), 32'd1);
    check("loss_data", 32'(bus.dataOut), 32'h5A);
    repeat (8) tick();

    // Accept-and-load on the exact completion edge.
    dataReady = 1'b1;
    tick();
    dataReady = 1'b0;
    send_byte(8'hAB, 1'b0);
    check("al_lock", 32'(obs_lock), 32'd1);
    send_byte(8'h11, 1'b0);
    check("al_first", 32'(obs_data), 32'h11);
    c0 = cnt_ovr;
    v0 = cnt_cerr;
    send_byte(8'h22, 1'b1);
    check("al_data", 32'(obs_data), 32'h22);
    check("al_valid", 32'(obs_valid), 32'd1);
    check("al_no_ovr", 32'(obs_ovr), 32'd0);
    check("al_ovr_count", cnt_ovr - c0, 32'd0);
    check("al_valid_hold", 32'(bus.dataValid), 32'd1);
    check("al_no_cerr", cnt_cerr - v0, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
